// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD       = 2'd0,
    WAIT_READY = 2'd1,
    DONE       = 2'd2,
    ERROR      = 2'd3
  } seq_state_e;

  // Wide enough to hold the larger of the two terminal counts without wrapping.
  function automatic int counter_width(input int hold_cycles, input int timeout_cycles);
    int max_cycles;
    max_cycles = (hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles;
    return $clog2(max_cycles + 1);
  endfunction

  function automatic int index_width(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Clearable saturating up-counter with a terminal-count flag; shared by the
// hold phase and the ready-timeout phase of the sequencer.
module seq_timer
  import reset_seq_pkg::*;
#(
  parameter int Width = counter_width(16, 1024)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] limit_i,
  output logic             tc_o
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;

  // Next count: clear wins, otherwise count up and stick at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // True on the edge that completes limit_i counted edges since the last clear.
  assign tc_o = ({1'b0, count_q} + (Width + 1)'(1)) >= {1'b0, limit_i};

endmodule

// File: rtl/reset_sequencer.sv
// Releases NumStages reset domains one at a time, waiting for each stage's
// ready before holding off and releasing the next; flags a stage that times out.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NumStages     = 3,
  parameter int HoldCycles    = 16,
  parameter int TimeoutCycles = 1024
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                sw_reset_req,
  input  logic [NumStages-1:0]                stage_ready,
  output logic [NumStages-1:0]                stage_reset,
  output logic                                all_ready,
  output logic                                error,
  output logic [index_width(NumStages)-1:0]   error_stage
);

  localparam int IdxW = index_width(NumStages);
  localparam int CntW = counter_width(HoldCycles, TimeoutCycles);
  localparam logic [CntW-1:0] HoldLimit    = CntW'(HoldCycles);
  localparam logic [CntW-1:0] TimeoutLimit = CntW'(TimeoutCycles);
  localparam logic [IdxW-1:0] LastIdx      = IdxW'(NumStages - 1);

  seq_state_e state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [NumStages-1:0] stage_reset_q, stage_reset_d;
  logic                 all_ready_q, all_ready_d;
  logic                 error_q, error_d;
  logic [IdxW-1:0]      error_stage_q, error_stage_d;

  logic [NumStages-1:0] prior_mask_s;
  logic                 lost_ready_s;
  logic                 cur_ready_s;
  logic                 restart_s;
  logic                 timer_clr_s;
  logic                 timer_en_s;
  logic                 timer_tc_s;
  logic [CntW-1:0]      timer_limit_s;

  // Stages whose ready must stay high: those already handed off, or all in DONE.
  always_comb begin
    prior_mask_s = '0;
    for (int k = 0; k < NumStages; k++) begin
      if (state_q == DONE) begin
        prior_mask_s[k] = 1'b1;
      end else if (((state_q == HOLD) || (state_q == WAIT_READY)) && (k < int'(idx_q))) begin
        prior_mask_s[k] = 1'b1;
      end else begin
        prior_mask_s[k] = 1'b0;
      end
    end
  end

  assign lost_ready_s  = |(prior_mask_s & ~stage_ready);
  assign cur_ready_s   = stage_ready[idx_q];
  assign timer_limit_s = (state_q == WAIT_READY) ? TimeoutLimit : HoldLimit;

  seq_timer #(
    .Width (CntW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (timer_clr_s),
    .en_i    (timer_en_s),
    .limit_i (timer_limit_s),
    .tc_o    (timer_tc_s)
  );

  // Next-state logic; restart requests outrank ready and timeout.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    restart_s  = 1'b0;
    timer_en_s = 1'b0;
    if (sw_reset_req || lost_ready_s) begin
      state_d   = HOLD;
      idx_d     = '0;
      restart_s = 1'b1;
    end else begin
      case (state_q)
        HOLD: begin
          timer_en_s = 1'b1;
          if (timer_tc_s) begin
            state_d = WAIT_READY;
          end else begin
            state_d = HOLD;
          end
        end
        WAIT_READY: begin
          timer_en_s = 1'b1;
          if (cur_ready_s) begin
            if (idx_q == LastIdx) begin
              state_d = DONE;
            end else begin
              state_d = HOLD;
              idx_d   = idx_q + IdxW'(1);
            end
          end else if (timer_tc_s) begin
            state_d = ERROR;
          end else begin
            state_d = WAIT_READY;
          end
        end
        DONE:  state_d = DONE;
        ERROR: state_d = ERROR;
        default: begin
          state_d   = HOLD;
          idx_d     = '0;
          restart_s = 1'b1;
        end
      endcase
    end
  end

  assign timer_clr_s = restart_s || (state_d != state_q) || (idx_d != idx_q);

  // Output values are derived from the next state so they land with it.
  always_comb begin
    stage_reset_d = '1;
    for (int k = 0; k < NumStages; k++) begin
      if (state_d == DONE) begin
        stage_reset_d[k] = 1'b0;
      end else if (k < int'(idx_d)) begin
        stage_reset_d[k] = 1'b0;
      end else if ((k == int'(idx_d)) && (state_d == WAIT_READY)) begin
        stage_reset_d[k] = 1'b0;
      end else begin
        stage_reset_d[k] = 1'b1;
      end
    end
    all_ready_d   = (state_q == DONE) && (state_d == DONE);
    error_d       = (state_d == ERROR);
    if (state_d == ERROR) begin
      error_stage_d = idx_d;
    end else begin
      error_stage_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HOLD;
      idx_q         <= '0;
      stage_reset_q <= '1;
      all_ready_q   <= 1'b0;
      error_q       <= 1'b0;
      error_stage_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      stage_reset_q <= stage_reset_d;
      all_ready_q   <= all_ready_d;
      error_q       <= error_d;
      error_stage_q <= error_stage_d;
    end
  end

  assign stage_reset = stage_reset_q;
  assign all_ready   = all_ready_q;
  assign error       = error_q;
  assign error_stage = error_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed and randomized bench for reset_sequencer against a stage-segment
// reference model (each stage = H hold edges followed by up to T wait edges).
module tb_reset_sequencer;

  localparam int N = 3;
  localparam int H = 4;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       sw_reset_req;
  logic [2:0] stage_ready;
  logic [2:0] stage_reset;
  logic       all_ready;
  logic       error;
  logic [1:0] error_stage;

  reset_sequencer #(
    .NumStages     (N),
    .HoldCycles    (H),
    .TimeoutCycles (T)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sw_reset_req (sw_reset_req),
    .stage_ready  (stage_ready),
    .stage_reset  (stage_reset),
    .all_ready    (all_ready),
    .error        (error),
    .error_stage  (error_stage)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: current stage, edges into its segment, terminal flags.
  int m_idx;
  int m_seg;
  int m_age;
  bit m_done;
  bit m_err;

  int lat[N];
  int rel_age[N];
  bit force_low[N];
  bit rnd_lat;

  function automatic bit m_released(input int k);
    if (m_done) return 1'b1;
    if (m_err) return (k < m_idx);
    return (k < m_idx) || ((k == m_idx) && (m_seg >= H));
  endfunction

  function automatic logic [2:0] exp_reset();
    logic [2:0] v;
    for (int k = 0; k < N; k++) v[k] = ~m_released(k);
    return v;
  endfunction

  task automatic model_reset();
    m_idx  = 0;
    m_seg  = 0;
    m_age  = 0;
    m_done = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_edge(input bit sw, input logic [2:0] rdy);
    bit lost;
    lost = 1'b0;
    for (int k = 0; k < N; k++)
      if ((m_done || (k < m_idx)) && !rdy[k]) lost = 1'b1;
    if (sw || (!m_err && lost)) begin
      model_reset();
    end else if (m_err) begin
      m_err = 1'b1;
    end else if (m_done) begin
      m_age++;
    end else begin
      m_seg++;
      if (m_seg > H) begin
        if (rdy[m_idx]) begin
          if (m_idx == N - 1) begin
            m_done = 1'b1;
            m_age  = 0;
          end else begin
            m_idx++;
            m_seg = 0;
          end
        end else if (m_seg - H == T) begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive_ready();
    for (int k = 0; k < N; k++)
      stage_ready[k] = m_released(k) && (rel_age[k] >= lat[k] - 1) && !force_low[k];
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(sw_reset_req, stage_ready);
    for (int k = 0; k < N; k++) begin
      if (m_released(k)) begin
        rel_age[k]++;
        if ((rel_age[k] == 0) && rnd_lat) lat[k] = $urandom_range(1, T + 2);
      end else begin
        rel_age[k] = -1;
      end
    end
    #1;
    chk({tag, "_srst"}, 32'(stage_reset), 32'(exp_reset()));
    chk({tag, "_allrdy"}, 32'(all_ready), 32'(m_done && (m_age >= 1)));
    chk({tag, "_err"}, 32'(error), 32'(m_err));
    chk({tag, "_errstg"}, 32'(error_stage), m_err ? 32'(m_idx) : 32'd0);
    drive_ready();
  endtask

  initial begin
    reset        = 1'b1;
    sw_reset_req = 1'b0;
    stage_ready  = 3'b000;
    rnd_lat      = 1'b0;
    for (int k = 0; k < N; k++) begin
      lat[k]       = 2;
      rel_age[k]   = -1;
      force_low[k] = 1'b0;
    end
    model_reset();
    #1;
    chk("por_srst", 32'(stage_reset), 32'(3'b111));
    chk("por_err", 32'(error), 32'd0);
    repeat (2) cyc("rst");
    reset = 1'b0;

    // Nominal release: falls at 4, 10, 16; all_ready at 19.
    for (int e = 1; e <= 19; e++) begin
      cyc("seq");
      case (e)
        3:  chk("seq_e3", 32'(stage_reset), 32'(3'b111));
        4:  chk("seq_e4", 32'(stage_reset), 32'(3'b110));
        10: chk("seq_e10", 32'(stage_reset), 32'(3'b100));
        16: chk("seq_e16", 32'(stage_reset), 32'(3'b000));
        18: chk("seq_e18_allrdy", 32'(all_ready), 32'd0);
        19: chk("seq_e19_allrdy", 32'(all_ready), 32'd1);
        default: ;
      endcase
    end

    // One-cycle ready drop in DONE restarts everything.
    repeat (3) cyc("done");
    force_low[0] = 1'b1;
    drive_ready();
    cyc("drop");
    chk("drop_allrdy", 32'(all_ready), 32'd0);
    chk("drop_srst", 32'(stage_reset), 32'(3'b111));
    force_low[0] = 1'b0;
    drive_ready();
    for (int e = 1; e <= 19; e++) begin
      cyc("rep");
      case (e)
        4:  chk("rep_e4", 32'(stage_reset), 32'(3'b110));
        19: chk("rep_e19_allrdy", 32'(all_ready), 32'd1);
        default: ;
      endcase
    end

    // Stage 1 never ready: error on the 8th wait edge (edge 18).
    sw_reset_req = 1'b1;
    cyc("sw");
    chk("sw_srst", 32'(stage_reset), 32'(3'b111));
    sw_reset_req = 1'b0;
    lat[1] = 1000;
    drive_ready();
    for (int e = 1; e <= 22; e++) begin
      cyc("to");
      case (e)
        17: chk("to_e17_err", 32'(error), 32'd0);
        18: begin
          chk("to_e18_err", 32'(error), 32'd1);
          chk("to_e18_stg", 32'(error_stage), 32'd1);
          chk("to_e18_srst", 32'(stage_reset), 32'(3'b110));
        end
        22: chk("to_e22_srst", 32'(stage_reset), 32'(3'b110));
        default: ;
      endcase
    end

    // sw_reset_req in ERROR together with a ready drop.
    sw_reset_req = 1'b1;
    force_low[0] = 1'b1;
    drive_ready();
    cyc("swerr");
    chk("swerr_err", 32'(error), 32'd0);
    chk("swerr_stg", 32'(error_stage), 32'd0);
    chk("swerr_srst", 32'(stage_reset), 32'(3'b111));
    sw_reset_req = 1'b0;
    force_low[0] = 1'b0;
    lat[1]       = T;
    lat[2]       = 6;
    drive_ready();

    // Ready on exactly the timeout edge wins.
    for (int e = 1; e <= 24; e++) begin
      cyc("edge");
      case (e)
        4:  chk("edge_e4", 32'(stage_reset), 32'(3'b110));
        18: begin
          chk("edge_e18_err", 32'(error), 32'd0);
          chk("edge_e18_srst", 32'(stage_reset), 32'(3'b100));
        end
        22: chk("edge_e22", 32'(stage_reset), 32'(3'b000));
        default: ;
      endcase
    end

    // Asynchronous reset mid-wait for stage 2, checked before any clock edge.
    #2;
    reset = 1'b1;
    #1;
    chk("async_srst", 32'(stage_reset), 32'(3'b111));
    chk("async_allrdy", 32'(all_ready), 32'd0);
    chk("async_err", 32'(error), 32'd0);
    chk("async_stg", 32'(error_stage), 32'd0);
    model_reset();
    for (int k = 0; k < N; k++) rel_age[k] = -1;
    drive_ready();
    cyc("rst2");
    reset = 1'b0;

    // Random ready latencies, drops, software and hardware resets.
    rnd_lat = 1'b1;
    for (int k = 0; k < N; k++) lat[k] = $urandom_range(1, T + 2);
    for (int i = 0; i < 1500; i++) begin
      sw_reset_req = ($urandom_range(0, 39) == 0);
      reset        = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < N; k++) force_low[k] = ($urandom_range(0, 59) == 0);
      drive_ready();
      cyc("rnd");
    end
    sw_reset_req = 1'b0;
    reset        = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NumStages, default 3, meaning the number of reset domains released in order (legal range 1..16).
REQ-002 SHALL have parameter HoldCycles, default 16, meaning the clock cycles each stage waits before its reset is released (>=1).
REQ-003 SHALL have parameter TimeoutCycles, default 1024, meaning the maximum cycles to wait for a released stage's ready (>=1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port sw_reset_req, input, 1 bit: synchronous request to restart the sequence.
REQ-007 SHALL have port stage_ready, input, NumStages bits: init-done per stage, synchronous to clk.
REQ-008 SHALL have port stage_reset, output, NumStages bits: active-high reset per stage.
REQ-009 SHALL have port all_ready, output, 1 bit: all stages released and ready.
REQ-010 SHALL have port error, output, 1 bit: a stage timed out.
REQ-011 SHALL have port error_stage, output, max(1,$clog2(NumStages)) bits: index of the timed-out stage.

Function
REQ-012 SHALL implement the FSM states HOLD, WAIT_READY, DONE and ERROR, plus a stage index idx.
REQ-013 HOLD SHALL count HoldCycles rising edges, then deassert stage_reset[idx] on the HoldCycles-th edge and enter WAIT_READY.
REQ-014 WAIT_READY SHALL sample stage_ready[idx] each edge.
REQ-015 In WAIT_READY, if stage_ready[idx] is seen and idx<NumStages-1, the FSM SHALL increment idx and go to HOLD with the counter cleared; if idx=NumStages-1, it SHALL go to DONE.
REQ-016 In WAIT_READY, if ready is not seen within TimeoutCycles edges, the FSM SHALL go to ERROR.
REQ-017 If ready is seen on the same edge as timeout expiry, ready SHALL win.
REQ-018 all_ready SHALL be 1 only in DONE, registered, asserted on the edge following the last stage's ready.
REQ-019 ERROR SHALL set error=1 and error_stage=idx; stage_reset[idx..NumStages-1] SHALL remain asserted and earlier stages SHALL remain released; the FSM SHALL remain in ERROR until sw_reset_req or reset.
REQ-020 sw_reset_req=1 in any state SHALL, on the next edge, assert all stage_reset bits, clear error, all_ready, error_stage and idx, and enter HOLD.
REQ-021 In HOLD, WAIT_READY or DONE, a drop of stage_ready[k] for any already-ready stage k<idx (or any k in DONE) SHALL restart the sequence as in REQ-020 without setting error.
REQ-022 stage_ready bits of stages still in reset SHALL be ignored.
REQ-023 sw_reset_req SHALL take priority over ready, timeout and ready-drop on the same edge.
REQ-024 Counter width SHALL be $clog2(max(HoldCycles,TimeoutCycles)+1); the counter SHALL saturate and never wrap.
REQ-025 All outputs SHALL be driven directly from flops, with no combinational paths from inputs to outputs.

Reset
REQ-026 While reset=1, stage_reset SHALL be all ones, all_ready=0, error=0, error_stage=0, idx=0, the counter=0, and state=HOLD, applied asynchronously.
REQ-027 After reset deasserts, the first rising edge SHALL be counted as HOLD cycle 1.
REQ-028 Reset asserted mid-sequence, including in DONE or ERROR, SHALL immediately reassert all stage_reset bits.

Structure
REQ-029 Package reset_seq_pkg SHALL hold the state enum type and a function computing the counter width.
REQ-030 A single sub-module seq_timer SHALL provide a clearable, saturating up-counter with a terminal-count compare, used for both hold and timeout.
REQ-031 stage_ready sources in foreign clock domains SHALL be synchronized outside this block.

Verification (NumStages=3, HoldCycles=4, TimeoutCycles=8)
REQ-032 Release reset and return each ready 2 cycles after its stage_reset falls -> stage_reset falls at edges 4, 10 and 16; all_ready=1 at edge 19.
REQ-033 Hold stage_ready[1] at 0 -> error=1 and error_stage=1 on the 8th edge of WAIT_READY; stage_reset=3'b110 is held.
REQ-034 Return stage_ready[1] exactly on the 8th wait edge -> no error; the sequence continues to stage 2.
REQ-035 In DONE, drop stage_ready[0] for 1 cycle -> all_ready=0 and stage_reset=3'b111 on the next edge, then the full sequence repeats.
REQ-036 Assert sw_reset_req in ERROR on the same edge as a ready-drop -> error clears and HOLD restarts with idx=0.
REQ-037 Assert reset asynchronously mid-WAIT_READY for stage 2 -> stage_reset=3'b111 and all outputs reach reset values with no clock edge.
